// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that pushes one nibble per cycle through a single 4-bit CLA slice.
// Define CLA_SERIAL_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// RUN   | one nibble per cycle through the CLA slice, LSB nibble first
// DONE  | out_valid=1, result held until out_ready
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic              in_ready_q, out_valid_q, cout_q;
`ifdef CLA_SERIAL_OVF_EN
    logic              ovf_q;
`endif

    logic [3:0] an, bn, g, p, s;
    logic [4:0] c;

    always_comb begin
        an = '0;
        bn = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) begin
                an = a_q[4*i +: 4];
                bn = b_q[4*i +: 4];
            end
        end

        g    = an & bn;
        p    = an ^ bn;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];

        sum_d = sum_q;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) begin
                sum_d[4*i +: 4] = s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= c[4];
                    if (idx_q == IDXW'(NIB - 1)) begin
                        idx_q       <= '0;
                        cout_q      <= c[4];
`ifdef CLA_SERIAL_OVF_EN
                        ovf_q       <= c[4] ^ c[3];
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    // Ready only reappears the cycle after the output transfer.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_SERIAL_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed and randomised checks of cla_nibble_serial_adder at WIDTH=16.
module tb_cla_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_SERIAL_OVF_EN
    logic         ovf;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({tag, "_in_ready_timeout"}, 0, 1);
    endtask

    // Accept one pair, measure latency to out_valid, hold out_ready low for
    // `stall` cycles, then check the result and complete the transfer.
    task automatic run_pair(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic ci, input logic [W-1:0] exp_sum, input logic exp_cout,
                            input int stall);
        int lat = 0;
        wait_in_ready(tag);
        a = av; b = bv; cin = ci; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~av; b = ~bv; cin = ~ci;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, W / 4);
        for (int k = 0; k < stall; k++) tick();
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, cout, exp_cout);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic [W:0]   ref_full;
        logic [W-1:0] ra, rb;
        logic         rc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #23;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
`ifdef CLA_SERIAL_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        tick();

        run_pair("v1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);
        run_pair("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0);
        run_pair("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
        run_pair("top_carry", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0);
        run_pair("mixed", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0);
        run_pair("abcd", 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 0);

        // Backpressure: result stable, new in_valid ignored while in DONE.
        wait_in_ready("bp");
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h0100; b = 16'h0200; cin = 1'b1;
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        check("bp_out_valid", out_valid, 1);
        held_sum = sum;
        check("bp_sum", held_sum, 16'h3333);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_sum", sum, 16'h3333);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_xfer_out_valid", out_valid, 0);
        check("bp_xfer_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_next_accept", in_ready, 0);
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        check("bp_next_sum", sum, 16'h0301);
        check("bp_next_cout", cout, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of RUN.
        wait_in_ready("mrst");
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_sum", sum, 0);
        check("mrst_cout", cout, 0);
        #2;
        rst_n = 1'b1;
        tick();
        run_pair("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0);

`ifdef CLA_SERIAL_OVF_EN
        run_pair("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0);
        check("ovf_pos_flag", ovf, 1);
        run_pair("ovf_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
        check("ovf_wrap_flag", ovf, 0);
`endif

        for (int n = 0; n < 300; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_pair("rand", ra, rb, rc, ref_full[W-1:0], ref_full[W], $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
